sdf_delay_line: RTL and testbench
=================================

Name: sdf_delay_line

Overview:
Runtime-programmable complex delay line for the R2²SDF pipeline stages, replacing the fixed shift-register delay. It uses a circular buffer of MAX_DEPTH entries and advances only on valid samples, so the pipeline can stall. One build serves every stage and FFT size via a depth register. A depth of 0 gives a registered bypass, and the block generates a valid output plus a primed status flag.

Parameters:
MAX_DEPTH, 32, buffer entries; any integer >= 1 (power of 2 not required)
WIDTH, 8, signed bit width of each of re/im
DEPTH_W, $clog2(MAX_DEPTH+1), width of depth port (localparam, derived)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  sample present; buffer advances only when 1
in_re  in  WIDTH  signed real input
in_im  in  WIDTH  signed imaginary input
depth  in  DEPTH_W  requested delay in valid samples, 0..MAX_DEPTH; sampled only on flush
flush  in  1  synchronous clear of pointer/fill state and latch of depth
out_valid  out  1  registered; out_re/out_im hold a delayed sample
out_re  out  WIDTH  signed delayed real output
out_im  out  WIDTH  signed delayed imaginary output
primed  out  1  fill count >= depth_r (buffer fully loaded)

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_re=out_im=0, primed=0.
  - wr_ptr=0, fill_cnt=0, depth_r=MAX_DEPTH.
  - Buffer memory is not reset.
- flush=1 at an edge:
  - wr_ptr=0, fill_cnt=0, out_valid=0, out_re=out_im=0, primed=0.
  - depth_r = min(depth, MAX_DEPTH).
  - flush wins over a simultaneous in_valid; that sample is dropped.
  - depth changes outside flush are ignored.
- Advance (in_valid=1, flush=0), depth_r>0:
  - rd_addr = (wr_ptr - depth_r) mod MAX_DEPTH, with explicit wrap for non-pow2 sizes.
  - Read happens before write: mem[rd_addr] is captured pre-write. When depth_r=MAX_DEPTH, rd_addr==wr_ptr and the old entry is returned.
  - mem[wr_ptr] <= {in_re,in_im}; wr_ptr increments, wrapping from MAX_DEPTH-1 to 0.
  - fill_cnt increments, saturating at MAX_DEPTH.
  - If fill_cnt (pre-increment) >= depth_r: out_valid<=1 and out_re/out_im <= mem[rd_addr]. Otherwise out_valid<=0 and out_re/out_im <= 0.
- Advance, depth_r=0 (bypass): out_re/out_im <= in_re/in_im, out_valid<=1. Latency 1 cycle.
- Latency: the output pairs with the input from exactly depth_r valid samples earlier, and is presented 1 clk after the current advance edge. Idle cycles do not count toward the delay.
- No advance (in_valid=0, flush=0): out_valid<=0; out_re/out_im and all state hold.
- primed is combinational from registers: fill_cnt >= depth_r. It is 1 immediately after a flush to depth 0.
- No arithmetic on data; samples pass bit-exact.

Decomposition:
- Shared package fft_pkg:
  - cplx_t: packed {re,im} of WIDTH, parameterised via typedef in the using module.
  - Function wrap_sub(a,b,mod) for modular pointer subtraction.
  - Clog2 helper constant function.
- One sub-module, sdf_delay_mem: MAX_DEPTH x 2*WIDTH memory with one write port and one read port, read-before-write, no reset, synthesisable to distributed/block RAM.
- Pointer, fill and valid control stay in sdf_delay_line.

Test Plan:
- Reset then flush with depth=4; ramp in_re=1,2,3... and in_im=-in_re, in_valid=1 continuous -> out_valid first 1 on the output following the 5th input; that output=(1,-1), then 2,3... bit-exact; primed=1 after the 4th input.
- depth=4 with in_valid pattern 1,0,0,1,1,0,1,1,1 -> delay counts valid samples only; out_valid pulses only after advance edges; outputs hold during gaps.
- depth=MAX_DEPTH=32, 100 continuous samples -> output k is input k-32; read-before-write collision is correct; pointer wraps cleanly through 0.
- depth=0 bypass, input 0x7F/0x80 -> out equals in 1 cycle later with out_valid=1, sign preserved; depth=40 on the flush clamps to 32.
- Mid-stream flush with in_valid=1, new depth=2 -> that sample is dropped; out_valid=0 for the next two advances; the third advance outputs the first post-flush sample.
- rst asserted asynchronously between edges mid-stream -> outputs 0 and out_valid=0 immediately (no clk edge); after release depth_r=32 and a full refill is required before out_valid.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared helpers for the FFT pipeline stages
package fft_pkg;

    function automatic int clog2_c(input int n);
        int r = 0;
        int v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Modular a-b for a < m, b <= m; avoids relying on power-of-2 wrap.
    function automatic int wrap_sub(input int a, input int b, input int m);
        return (a >= b) ? (a - b) : (a + m - b);
    endfunction

endpackage

// File: rtl/sdf_delay_mem.sv
// rtl/sdf_delay_mem.sv - unreset 1W/1R sample store with read-before-write
module sdf_delay_mem #(
    parameter int DEPTH = 32,
    parameter int DW    = 16,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Asynchronous read returns the pre-edge contents, so a same-address write wins only next cycle.
    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - runtime-depth circular delay line advancing on valid samples
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter  int MAX_DEPTH = 32,
    parameter  int WIDTH     = 8,
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic [DEPTH_W-1:0]      depth,
    input  logic                    flush,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    primed
);

    localparam int PTR_W = (MAX_DEPTH > 1) ? clog2_c(MAX_DEPTH) : 1;

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_t;

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [DEPTH_W-1:0] r_fill_cnt;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_out_valid;
    cplx_t              r_out;

    logic [PTR_W-1:0]   w_rd_addr;
    logic               w_adv;
    cplx_t              w_wr_data;
    cplx_t              w_rd_data;

    assign w_adv       = in_valid && !flush;
    assign w_wr_data   = '{re: in_re, im: in_im};
    assign w_rd_addr   = PTR_W'(wrap_sub(int'(r_wr_ptr), int'(r_depth), MAX_DEPTH));

    sdf_delay_mem #(
        .DEPTH (MAX_DEPTH),
        .DW    (2 * WIDTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_adv),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_depth     <= DEPTH_W'(MAX_DEPTH);
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_depth     <= (depth > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : depth;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (in_valid) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (r_fill_cnt != DEPTH_W'(MAX_DEPTH)) begin
                r_fill_cnt <= r_fill_cnt + DEPTH_W'(1);
            end
            if (r_depth == '0) begin
                r_out_valid <= 1'b1;
                r_out       <= w_wr_data;
            end else if (r_fill_cnt >= r_depth) begin
                r_out_valid <= 1'b1;
                r_out       <= w_rd_data;
            end else begin
                r_out_valid <= 1'b0;
                r_out       <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out.re;
    assign out_im    = r_out.im;
    assign primed    = (r_fill_cnt >= r_depth);

endmodule

// File: tb/tb_sdf_delay_line.sv
// tb/tb_sdf_delay_line.sv - scoreboard bench for sdf_delay_line
module tb_sdf_delay_line;

    localparam int MAXD = 32;
    localparam int W    = 8;
    localparam int DW   = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic [DW-1:0]       depth;
    logic                flush;
    logic                out_valid;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                primed;

    always #5 clk = ~clk;

    sdf_delay_line #(.MAX_DEPTH(MAXD), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .depth     (depth),
        .flush     (flush),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .primed    (primed)
    );

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } samp_t;

    samp_t hist[$];
    samp_t exp_q[$];
    int    mdepth;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got out_valid=1 (%0d,%0d) expected no output", out_re, out_im);
            end else begin
                samp_t e;
                e = exp_q.pop_front();
                if (out_re !== e.re || out_im !== e.im) begin
                    n_err++;
                    $display("FAIL data: got (%0d,%0d) expected (%0d,%0d)", out_re, out_im, e.re, e.im);
                end
            end
        end
    end

    // Reference: the output of advance k since flush is input k-D, valid once k >= D.
    task automatic cycle(input bit v, input int re, input int im, input bit fl, input int d);
        samp_t s;
        in_valid = v;
        in_re    = re[W-1:0];
        in_im    = im[W-1:0];
        flush    = fl;
        depth    = d[DW-1:0];
        if (fl) begin
            mdepth = (d > MAXD) ? MAXD : d;
            hist.delete();
        end else if (v) begin
            s.re = re[W-1:0];
            s.im = im[W-1:0];
            hist.push_back(s);
            if (mdepth == 0) exp_q.push_back(s);
            else if (hist.size() > mdepth) exp_q.push_back(hist[hist.size() - 1 - mdepth]);
            if (hist.size() > MAXD + 1) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycle(input bit v);
        cycle(v, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0, 0);
    endtask

    int pat[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

    initial begin
        int prev;
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; depth = '0; flush = 1'b0;
        mdepth = MAXD;
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_primed", int'(primed), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        cycle(0, 0, 0, 1, 4);
        check("flush4_primed", int'(primed), 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1, i, -i, 0, 0);
            if (i == 1) begin
                check("fill_valid", int'(out_valid), 0);
                check("fill_zero", int'(out_re), 0);
            end
            if (i == 3) check("primed_after3", int'(primed), 0);
            if (i == 4) check("primed_after4", int'(primed), 1);
            if (i == 5) begin
                check("first_valid", int'(out_valid), 1);
                check("first_re", int'(out_re), 1);
                check("first_im", int'(out_im), -1);
            end
        end

        cycle(0, 0, 0, 1, 4);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 9; i++) begin
                prev = int'(out_re);
                cycle(pat[i] != 0, 10 + 9 * r + i, -(10 + 9 * r + i), 0, 0);
                if (pat[i] == 0) begin
                    check("gap_valid", int'(out_valid), 0);
                    check("gap_hold", int'(out_re), prev);
                end
            end
        end

        cycle(0, 0, 0, 1, 32);
        for (int i = 0; i < 100; i++) rnd_cycle(1);

        cycle(0, 0, 0, 1, 0);
        check("bypass_primed", int'(primed), 1);
        cycle(1, 127, -128, 0, 0);
        check("bypass_re", int'(out_re), 127);
        check("bypass_im", int'(out_im), -128);
        check("bypass_valid", int'(out_valid), 1);
        cycle(1, -128, 127, 0, 0);
        check("bypass_neg", int'(out_re), -128);

        cycle(0, 0, 0, 1, 40);
        for (int i = 0; i < 40; i++) begin
            rnd_cycle(1);
            if (i == 30) check("clamp_not_primed", int'(primed), 0);
            if (i == 31) check("clamp_primed", int'(primed), 1);
        end

        cycle(0, 0, 0, 1, 3);
        for (int i = 0; i < 6; i++) rnd_cycle(1);
        cycle(1, 99, 99, 1, 2);
        check("midflush_valid", int'(out_valid), 0);
        cycle(1, 50, -50, 0, 0);
        check("post_flush_adv1", int'(out_valid), 0);
        cycle(1, 51, -51, 0, 0);
        check("post_flush_adv2", int'(out_valid), 0);
        cycle(1, 52, -52, 0, 0);
        check("post_flush_adv3", int'(out_valid), 1);
        check("post_flush_data", int'(out_re), 50);

        cycle(0, 0, 0, 1, 5);
        for (int i = 0; i < 10; i++) rnd_cycle(1);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        hist.delete();
        mdepth = MAXD;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_re", int'(out_re), 0);
        check("async_primed", int'(primed), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rnd_cycle(1);
            if (i == 31) check("refill_no_valid", int'(out_valid), 0);
            if (i == 32) check("refill_valid", int'(out_valid), 1);
        end

        for (int r = 0; r < 6; r++) begin
            cycle(0, 0, 0, 1, int'($urandom_range(0, 40)));
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 29) == 0) cycle(1, 0, 0, 1, int'($urandom_range(0, 40)));
                else rnd_cycle($urandom_range(0, 3) != 0);
            end
        end

        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
